// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared loader state encoding and header constants.
package program_loader_pkg;
  typedef enum logic [2:0] {HDR0, HDR1, LOAD, RUN, DONE} state_e;
  localparam int HDR_BYTES = 2;
  localparam int HDR_W = 8 * HDR_BYTES;
endpackage

// File: rtl/program_loader_byte_assembler.sv
// byte_assembler: shifts bytes LSB-first into a word; word_valid_o pulses with the completing byte.
module byte_assembler #(
  parameter int WORD_BYTES = 2,
  localparam int WORD_W = 8 * WORD_BYTES,
  localparam int CW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic [7:0]        byte_i,
  input  logic              valid_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last;
  // the completed word is presented in the same cycle as its final byte
  always_comb begin
    last = cnt_q == CW'(WORD_BYTES - 1);
    shift_d = (shift_q >> 8) | (WORD_W'(byte_i) << (WORD_W - 8));
    word_o = shift_d;
    word_valid_o = valid_i & last;
    cnt_d = clr_i ? '0 : !valid_i ? cnt_q : last ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q <= '0;
    end else begin
      shift_q <= clr_i ? '0 : valid_i ? shift_d : shift_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: loads a length-prefixed byte stream into instruction memory, then runs the processor.
// Optional RUN_CYCLE_COUNT_EN enables the run_cycles counter; otherwise run_cycles reads 0.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W = 8,
  parameter int CNT_W = 32,
  localparam int WORD_W = 8 * WORD_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              start,
  input  logic              finish_process,
  output logic              busy,
  output logic              done,
  output logic              load_err,
  output logic [CNT_W-1:0]  run_cycles
);
  localparam logic [HDR_W:0] DEPTH = (HDR_W + 1)'(1) << ADDR_W;
  state_e state_q, state_d;
  logic [7:0] lo_q, lo_d;
  logic [ADDR_W:0] n_q, n_d, wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d, word;
  logic in_ready_q, mem_we_q, mem_we_d, start_q, start_d, busy_q;
  logic done_q, done_d, load_err_q, load_err_d;
  logic acc, clr, word_valid;
  logic [HDR_W:0] hdr_n;
  byte_assembler #(.WORD_BYTES(WORD_BYTES)) u_asm (
    .clk(clk),
    .reset(reset),
    .clr_i(clr),
    .byte_i(in_data),
    .valid_i(acc && state_q == LOAD),
    .word_o(word),
    .word_valid_o(word_valid)
  );
  always_comb begin
    acc = in_valid & in_ready_q;
    hdr_n = {1'b0, in_data, lo_q};
    state_d = state_q;
    lo_d = lo_q;
    n_d = n_q;
    wcnt_d = wcnt_q;
    mem_we_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d = done_q;
    load_err_d = load_err_q;
    clr = 1'b0;
    case (state_q)
      HDR0, DONE: if (acc) begin
        lo_d = in_data;
        state_d = HDR1;
        done_d = 1'b0;
        load_err_d = 1'b0;
        clr = 1'b1;
      end
      HDR1: if (acc) begin
        clr = 1'b1;
        n_d = hdr_n[ADDR_W:0];
        wcnt_d = '0;
        state_d = hdr_n == '0 ? RUN : hdr_n > DEPTH ? DONE : LOAD;
        load_err_d = hdr_n > DEPTH;
      end
      LOAD: if (word_valid) begin
        mem_we_d = 1'b1;
        mem_addr_d = wcnt_q[ADDR_W-1:0];
        mem_wdata_d = word;
        wcnt_d = wcnt_q + 1'b1;
        state_d = wcnt_d == n_q ? RUN : LOAD;
      end
      RUN: if (start_q & finish_process) begin
        state_d = DONE;
        done_d = 1'b1;
      end
      default: state_d = HDR0;
    endcase
    // start trails RUN entry by one cycle so the last memory write lands first
    start_d = state_q == RUN && state_d == RUN;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HDR0;
      lo_q <= '0;
      n_q <= '0;
      wcnt_q <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      mem_we_q <= 1'b0;
      in_ready_q <= 1'b0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      n_q <= n_d;
      wcnt_q <= wcnt_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q <= mem_we_d;
      in_ready_q <= state_d != RUN;
      start_q <= start_d;
      busy_q <= state_d == HDR1 || state_d == LOAD || state_d == RUN;
      done_q <= done_d;
      load_err_q <= load_err_d;
    end
  end
`ifdef RUN_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cyc_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cyc_q <= '0;
    else if (state_d == RUN && state_q != RUN) cyc_q <= '0;
    else if (start_q && !(&cyc_q)) cyc_q <= cyc_q + 1'b1;
  end
  assign run_cycles = cyc_q;
`else
  assign run_cycles = '0;
`endif
  assign in_ready = in_ready_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign start = start_q;
  assign busy = busy_q;
  assign done = done_q;
  assign load_err = load_err_q;
endmodule
